// File: rtl/regfile_writeback.sv
// Write-side initiator for the 32x32 register file.
// ALU results always take the single write port the following cycle; load
// results are aligned, extended and queued, then drained into cycles the ALU
// leaves free. A younger ALU write to the same rd kills any older queued load
// so the load can never overwrite the newer value.
module regfile_writeback #(
    parameter int LD_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [31:0]      ld_data,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       ld_byte_off,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_write_data,
    output logic             rf_reg_write,
    output logic [31:0]      ld_busy_mask,
    output logic [CNT_W-1:0] ld_count
);

    localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

    logic [31:0]         fifo_ext [LD_DEPTH];
    logic [4:0]          fifo_rd  [LD_DEPTH];
    logic [LD_DEPTH-1:0] fifo_live;
    logic [LD_DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic        alu_claim;
    logic        enq;
    logic        head_valid;
    logic        head_live;
    logic        pop;
    logic        load_write;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign ld_ready   = (ld_count < CNT_W'(LD_DEPTH));
    assign alu_claim  = alu_valid && (alu_rd != 5'd0);
    assign enq        = ld_valid && ld_ready;
    assign head_valid = (ld_count != '0);
    assign head_live  = fifo_live[rd_ptr];
    assign load_write = head_valid && head_live && !alu_claim;
    assign pop        = head_valid && (!head_live || !alu_claim);

    // Align the memory word to the byte offset and sign/zero-extend by load type.
    always_comb begin
        shifted = ld_data >> {ld_byte_off, 3'b000};
        ext     = ld_data;
        case (ld_funct3)
            3'd0:    ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    ext = {24'd0, shifted[7:0]};
            3'd5:    ext = {16'd0, shifted[15:0]};
            default: ext = ld_data;
        endcase
    end

    // An entry is occupied when its distance from the head is below the count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < ld_count);
        end
    end

    // Busy mask is derived only from stored FIFO state, so it never depends on this cycle's inputs.
    always_comb begin
        ld_busy_mask = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (entry_valid[i] && fifo_live[i]) begin
                ld_busy_mask[fifo_rd[i]] = 1'b1;
            end
        end
        ld_busy_mask[0] = 1'b0;
    end

    // Load FIFO: enqueue, kill on younger ALU writes, and pop the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ld_count  <= '0;
            fifo_live <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                fifo_ext[i] <= '0;
                fifo_rd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                if (alu_claim && entry_valid[i] && (fifo_rd[i] == alu_rd)) begin
                    fifo_live[i] <= 1'b0;
                end
            end
            if (enq) begin
                fifo_ext[wr_ptr]  <= ext;
                fifo_rd[wr_ptr]   <= ld_rd;
                fifo_live[wr_ptr] <= (ld_rd != 5'd0) && !(alu_claim && (ld_rd == alu_rd));
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   ld_count <= ld_count + CNT_W'(1);
                2'b01:   ld_count <= ld_count - CNT_W'(1);
                default: ld_count <= ld_count;
            endcase
        end
    end

    // Write port: ALU has priority, otherwise a live head drains; idle cycles hold rd/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_reg_write  <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
        end else if (alu_claim) begin
            rf_reg_write  <= 1'b1;
            rf_rd         <= alu_rd;
            rf_write_data <= alu_data;
        end else if (load_write) begin
            rf_reg_write  <= 1'b1;
            rf_rd         <= fifo_rd[rd_ptr];
            rf_write_data <= fifo_ext[rd_ptr];
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vectors push the expected register
// writes into a scoreboard queue; a monitor pops and compares every write the
// DUT presents. Directed checks cover busy mask, count, ready and timing.
module tb_regfile_writeback;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;
    logic [31:0] ld_busy_mask;
    logic [2:0]  ld_count;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    regfile_writeback #(.LD_DEPTH(4), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_funct3     (ld_funct3),
        .ld_byte_off   (ld_byte_off),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .ld_busy_mask  (ld_busy_mask),
        .ld_count      (ld_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Drive one cycle of inputs, let the edge capture them, then drop the valids.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 input logic [2:0] f3, input logic [1:0] off);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adata;
        ld_valid    = lv;
        ld_rd       = lrd;
        ld_data     = ldata;
        ld_funct3   = f3;
        ld_byte_off = off;
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (!reset && rf_reg_write) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected write: got rd=%0d data=%h expected none", rf_rd, rf_write_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                checkOutput("write rd", {27'd0, rf_rd}, {27'd0, w.rd});
                checkOutput("write data", rf_write_data, w.data);
            end
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t ext_vecs[10] = '{
        '{5'd1,  3'd0, 2'd1, 32'hFFFFFF80},
        '{5'd2,  3'd4, 2'd1, 32'h00000080},
        '{5'd3,  3'd1, 2'd2, 32'h00001234},
        '{5'd4,  3'd2, 2'd2, 32'h123480FF},
        '{5'd5,  3'd0, 2'd3, 32'h00000012},
        '{5'd6,  3'd1, 2'd0, 32'hFFFF80FF},
        '{5'd7,  3'd5, 2'd0, 32'h000080FF},
        '{5'd8,  3'd6, 2'd1, 32'h123480FF},
        '{5'd0,  3'd2, 2'd0, 32'h00000000},
        '{5'd31, 3'd4, 2'd3, 32'h00000012}
    };

    initial begin
        reset       = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
        ld_funct3   = '0;
        ld_byte_off = '0;
        #1 reset = 1'b1;
        #2;
        $display("[TB] reset state");
        checkOutput("reset reg_write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("reset rd", {27'd0, rf_rd}, 32'd0);
        checkOutput("reset data", rf_write_data, 32'd0);
        checkOutput("reset mask", ld_busy_mask, 32'd0);
        checkOutput("reset count", {29'd0, ld_count}, 32'd0);
        checkOutput("reset ready", {31'd0, ld_ready}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        checkOutput("first edge reg_write", {31'd0, rf_reg_write}, 32'd0);

        $display("[TB] ALU write");
        pushExp(5'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        checkOutput("alu reg_write", {31'd0, rf_reg_write}, 32'd1);
        applyStimulus(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        checkOutput("alu rd0 no write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("idle holds rd", {27'd0, rf_rd}, 32'd5);

        $display("[TB] load extension");
        foreach (ext_vecs[i]) begin
            if (ext_vecs[i].rd != 5'd0) pushExp(ext_vecs[i].rd, ext_vecs[i].exp);
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, ext_vecs[i].rd, 32'h123480FF,
                          ext_vecs[i].f3, ext_vecs[i].off);
        end
        idle(4);
        checkOutput("ext count drained", {29'd0, ld_count}, 32'd0);
        checkOutput("ext mask clear", ld_busy_mask, 32'd0);

        $display("[TB] contention");
        pushExp(5'd7, 32'h70);
        pushExp(5'd7, 32'h71);
        pushExp(5'd7, 32'h72);
        pushExp(5'd3, 32'h33);
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd3, 32'h33, 3'd2, 2'd0);
        checkOutput("cont mask c1", {31'd0, ld_busy_mask[3]}, 32'd1);
        applyStimulus(1'b1, 5'd7, 32'h71, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        checkOutput("cont mask c2", {31'd0, ld_busy_mask[3]}, 32'd1);
        applyStimulus(1'b1, 5'd7, 32'h72, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        checkOutput("cont mask c3", {31'd0, ld_busy_mask[3]}, 32'd1);
        checkOutput("cont count", {29'd0, ld_count}, 32'd1);
        idle(1);
        checkOutput("cont load reg_write", {31'd0, rf_reg_write}, 32'd1);
        checkOutput("cont load rd", {27'd0, rf_rd}, 32'd3);
        checkOutput("cont mask after", {31'd0, ld_busy_mask[3]}, 32'd0);
        idle(2);

        $display("[TB] kill");
        pushExp(5'd5, 32'h50);
        pushExp(5'd9, 32'h90);
        applyStimulus(1'b1, 5'd5, 32'h50, 1'b1, 5'd9, 32'h99, 3'd2, 2'd0);
        checkOutput("kill mask set", {31'd0, ld_busy_mask[9]}, 32'd1);
        applyStimulus(1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        checkOutput("kill mask clear", {31'd0, ld_busy_mask[9]}, 32'd0);
        checkOutput("kill count held", {29'd0, ld_count}, 32'd1);
        idle(1);
        checkOutput("kill count zero", {29'd0, ld_count}, 32'd0);
        checkOutput("kill no write", {31'd0, rf_reg_write}, 32'd0);
        pushExp(5'd10, 32'hA0);
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd10, 32'hAA, 3'd2, 2'd0);
        checkOutput("same-cycle kill mask", {31'd0, ld_busy_mask[10]}, 32'd0);
        checkOutput("same-cycle kill count", {29'd0, ld_count}, 32'd1);
        idle(1);
        checkOutput("same-cycle no write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("same-cycle count zero", {29'd0, ld_count}, 32'd0);
        idle(2);

        $display("[TB] full FIFO");
        for (int k = 0; k < 5; k++) pushExp(5'd11, 32'hB0 + k);
        for (int k = 0; k < 4; k++) pushExp(5'(12 + k), 32'hC0 + k);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd11, 32'hB0 + k, 1'b1, 5'(12 + k), 32'hC0 + k, 3'd2, 2'd0);
        end
        checkOutput("full count", {29'd0, ld_count}, 32'd4);
        checkOutput("full ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("full mask", ld_busy_mask, 32'h0000F000);
        applyStimulus(1'b1, 5'd11, 32'hB4, 1'b1, 5'd16, 32'hDEAD, 3'd2, 2'd0);
        checkOutput("full refused count", {29'd0, ld_count}, 32'd4);
        idle(1);
        checkOutput("full drain rd", {27'd0, rf_rd}, 32'd12);
        checkOutput("full drain count", {29'd0, ld_count}, 32'd3);
        checkOutput("full drain ready", {31'd0, ld_ready}, 32'd1);
        idle(4);
        checkOutput("full empty", {29'd0, ld_count}, 32'd0);

        $display("[TB] reset mid-op");
        for (int k = 0; k < 3; k++) pushExp(5'd17, 32'hE0 + k);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 5'd17, 32'hE0 + k, 1'b1, 5'(18 + k), 32'hF0 + k, 3'd2, 2'd0);
        end
        checkOutput("pre-reset count", {29'd0, ld_count}, 32'd3);
        checkOutput("pre-reset mask", ld_busy_mask, 32'h001C0000);
        #5;
        reset = 1'b1;
        #1;
        checkOutput("midreset reg_write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("midreset rd", {27'd0, rf_rd}, 32'd0);
        checkOutput("midreset data", rf_write_data, 32'd0);
        checkOutput("midreset mask", ld_busy_mask, 32'd0);
        checkOutput("midreset count", {29'd0, ld_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(5);
        checkOutput("post-reset count", {29'd0, ld_count}, 32'd0);
        checkOutput("post-reset reg_write", {31'd0, rf_reg_write}, 32'd0);

        checkOutput("scoreboard empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
